bouton_impulsion: RTL

//  Front-end conditioner for one active-low push button on the DE board
//  (one instance each for suivant_n and lancer_n). It produces the active-high

---
 rtl/bouton_impulsion.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bouton_impulsion.sv
// Push-button conditioner: synchroniser, debounce counter and press/hold FSM.
// Produces a clean pressed level, press/repeat strobes and a release strobe.
module bouton_impulsion #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic bouton_n,
    output logic appui,
    output logic impulsion,
    output logic relache
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]   RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]   RP_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0]   RW_ONE  = RW'(1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    localparam logic [1:0] S_REPOS   = 2'd0;
    localparam logic [1:0] S_ATTENTE = 2'd1;
    localparam logic [1:0] S_REPETE  = 2'd2;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic [DB_W-1:0] r_db_cnt;
    logic [1:0]      r_state;
    logic [RW-1:0]   r_rep_cnt;
    logic            r_appui;
    logic            r_impulsion;
    logic            r_relache;

    logic            w_diff;
    logic            w_pressed;
    logic [1:0]      w_state_nxt;
    logic [RW-1:0]   w_rep_nxt;
    logic            w_imp_nxt;
    logic            w_rel_nxt;

    // Two-stage synchroniser; resets to the released level (1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bouton_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_diff    = (r_sync2 != r_stable);
    assign w_pressed = ~r_stable;

    // Debounce: accept a new level after DEBOUNCE_CYCLES unbroken differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b1;
            r_db_cnt <= '0;
        end else if (!w_diff) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_stable <= r_sync2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
        end
    end

    // Press/hold FSM next-state and strobe decode; release wins over repeat.
    always_comb begin
        w_state_nxt = r_state;
        w_rep_nxt   = r_rep_cnt;
        w_imp_nxt   = 1'b0;
        w_rel_nxt   = 1'b0;
        case (r_state)
            S_REPOS: begin
                w_rep_nxt = '0;
                if (w_pressed) begin
                    w_state_nxt = S_ATTENTE;
                    w_imp_nxt   = 1'b1;
                end
            end
            S_ATTENTE: begin
                if (!w_pressed) begin
                    w_state_nxt = S_REPOS;
                    w_rel_nxt   = 1'b1;
                    w_rep_nxt   = '0;
                end else if (!REPEAT_EN) begin
                    w_rep_nxt = '0;
                end else if (r_rep_cnt == RD_LAST) begin
                    w_state_nxt = S_REPETE;
                    w_imp_nxt   = 1'b1;
                    w_rep_nxt   = '0;
                end else begin
                    w_rep_nxt = r_rep_cnt + RW_ONE;
                end
            end
            S_REPETE: begin
                if (!w_pressed) begin
                    w_state_nxt = S_REPOS;
                    w_rel_nxt   = 1'b1;
                    w_rep_nxt   = '0;
                end else if (r_rep_cnt == RP_LAST) begin
                    w_imp_nxt = 1'b1;
                    w_rep_nxt = '0;
                end else begin
                    w_rep_nxt = r_rep_cnt + RW_ONE;
                end
            end
            default: begin
                w_state_nxt = S_REPOS;
                w_rep_nxt   = '0;
            end
        endcase
    end

    // FSM state, repeat counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_REPOS;
            r_rep_cnt   <= '0;
            r_appui     <= 1'b0;
            r_impulsion <= 1'b0;
            r_relache   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rep_cnt   <= w_rep_nxt;
            r_appui     <= (w_state_nxt != S_REPOS);
            r_impulsion <= w_imp_nxt;
            r_relache   <= w_rel_nxt;
        end
    end

    assign appui     = r_appui;
    assign impulsion = r_impulsion;
    assign relache   = r_relache;

endmodule
